stream_reg_arbiter: RTL

- Shares one output stream register (32-bit valid/ready payload holder, same semantics as the gen1 set registers) between NUM_REQ requesters.
- Sits between several config-writing sources (CFU instruction decoder, sequencer, DMA-side loader) and a single downstream consumer.
- Round-robin arbitration with optional burst locking, so a multi-word write from one requester is never interleaved with others.

---
 rtl/stream_reg_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stream_reg_arbiter.sv
// stream_reg_arbiter
//   Shares one output stream register (valid/ready payload holder) between
//   NUM_REQ requesters. Arbitration is round-robin. A word with req_last = 0
//   locks the arbiter to that requester until its last word is accepted, so
//   a burst from one requester is never interleaved with other requesters.
//
// Ports
//   clk             system clock, all state on the rising edge
//   rst             synchronous active-low reset (0 = reset)
//   req_valid       per-requester word valid
//   req_payload     requester i data at bits [i*WIDTH +: WIDTH]
//   req_last        final word of a burst (1 = single-word write)
//   req_ready       per-requester accept, one-hot or zero
//   output__valid   output register holds a word
//   output__payload held word
//   output__ready   downstream accepts
//   grant_id        requester index of the word in the output register
//   locked          arbiter is locked to a burst owner
module stream_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_payload,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     output__valid,
  output logic [WIDTH-1:0]         output__payload,
  input  logic                     output__ready,
  output logic [ID_W-1:0]          grant_id,
  output logic                     locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_payload_q, out_payload_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  logic              accept;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand;
  logic              sel_valid;
  logic [ID_W-1:0]   sel_idx;
  logic [WIDTH-1:0]  payload_arr [NUM_REQ];

  // Slice the flat payload bus into one word per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign payload_arr[gi] = req_payload[gi*WIDTH +: WIDTH];
  end

  // The register can take a new word when empty or draining this cycle.
  assign accept = !out_valid_q || output__ready;

  // Round-robin search starting just after the last granted index. The
  // candidate wraps explicitly at NUM_REQ-1 so non-power-of-two counts never
  // land on an index that has no requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (sel_valid && !req_last[sel_idx]) state_d = LOCKED;
      LOCKED: if (sel_valid && req_last[sel_idx])  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs (grant selection and lock flag)
  always_comb begin
    sel_idx   = win_idx;
    sel_valid = accept && win_found;
    if (state_q == LOCKED) begin
      sel_idx   = owner_q;
      sel_valid = accept && req_valid[owner_q];
    end
    // No requester is accepted while reset is asserted.
    if (!rst) sel_valid = 1'b0;
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = sel_valid && (sel_idx == ID_W'(gi));
  end

  assign locked = (state_q == LOCKED);

  // Pointer and owner only move on a fresh grant from IDLE; while locked the
  // owner is by construction the last granted index already.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (state_q == IDLE && sel_valid) begin
      rr_ptr_d = sel_idx;
      owner_d  = sel_idx;
    end
  end

  // Output register: load on transfer in (replaces a draining word with no
  // bubble), otherwise clear valid on transfer out. Payload and id persist.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_payload_d = out_payload_q;
    grant_id_d    = grant_id_q;
    if (sel_valid) begin
      out_valid_d   = 1'b1;
      out_payload_d = payload_arr[sel_idx];
      grant_id_d    = sel_idx;
    end else if (output__ready) begin
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q       <= '0;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
      grant_id_q    <= '0;
    end else begin
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_payload_q <= out_payload_d;
      grant_id_q    <= grant_id_d;
    end
  end

  assign output__valid   = out_valid_q;
  assign output__payload = out_payload_q;
  assign grant_id        = grant_id_q;

endmodule
